// File: rtl/heartbeat_pwm.sv
// heartbeat_pwm
//   Builds a double-pulse "heartbeat" brightness envelope and the PWM waveform
//   that carries it to the LED driver stage.
//
//   Envelope: IDLE -> RISE1 -> FALL1 -> GAP -> RISE2 -> FALL2 -> REST -> RISE1.
//   The envelope moves one step on each tick strobe while enable is high.
//   The PWM carrier runs at all times. The duty is latched only at a period
//   wrap, so a period never changes duty partway through.
//
// Ports
//   clk      in   system clock (12 MHz)
//   rst_n    in   asynchronous active-low reset
//   enable   in   run the envelope; low forces IDLE and clears the counters
//   tick     in   one-clk envelope step strobe
//   rest_len in   [3:0] rest ticks after the second beat, sampled on REST entry
//   pwm_out  out  registered PWM output
//   level    out  [7:0] current envelope brightness
//   phase    out  [2:0] FSM state code
//   beat     out  one-clk pulse following entry to RISE1 or RISE2
module heartbeat_pwm #(
  parameter int unsigned PRESCALE  = 47,
  parameter int unsigned STEP      = 64,
  parameter int unsigned PEAK2     = 160,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tick,
  input  logic [3:0] rest_len,
  output logic       pwm_out,
  output logic [7:0] level,
  output logic [2:0] phase,
  output logic       beat
);

  localparam int unsigned PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(PRESCALE);
  localparam logic [8:0]    STEP9  = 9'(STEP);
  localparam logic [7:0]    STEP8  = 8'(STEP);
  localparam logic [8:0]    PEAK9  = 9'(PEAK2);
  localparam logic [7:0]    PEAK8  = 8'(PEAK2);
  localparam logic [3:0]    GAP4   = 4'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RISE1 = 3'd1,
    S_FALL1 = 3'd2,
    S_GAP   = 3'd3,
    S_RISE2 = 3'd4,
    S_FALL2 = 3'd5,
    S_REST  = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_level, w_level_nxt;
  logic [3:0]    r_gap_cnt, w_gap_nxt;
  logic [3:0]    r_rest_cnt, w_rest_nxt;
  logic          r_beat, w_beat_nxt;

  logic [PW-1:0] r_pre;
  logic [7:0]    r_pwm_cnt;
  logic [7:0]    r_lvl_lat;
  logic          r_pwm;

  logic [8:0]    w_sum;
  logic [7:0]    w_up1;
  logic [7:0]    w_up2;
  logic [7:0]    w_dn;

  // Step arithmetic. The sum uses 9 bits so that saturation can see any overflow.
  assign w_sum = {1'b0, r_level} + STEP9;
  assign w_up1 = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_up2 = (w_sum >= PEAK9) ? PEAK8 : w_sum[7:0];
  assign w_dn  = (r_level <= STEP8) ? '0 : r_level - STEP8;

  // Envelope FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_level    <= '0;
      r_gap_cnt  <= '0;
      r_rest_cnt <= '0;
      r_beat     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_rest_cnt <= w_rest_nxt;
      r_beat     <= w_beat_nxt;
    end
  end

  // Envelope next-state logic. A low enable takes priority over a tick in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_gap_nxt   = r_gap_cnt;
    w_rest_nxt  = r_rest_cnt;
    w_beat_nxt  = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_level_nxt = '0;
      w_gap_nxt   = '0;
      w_rest_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_level_nxt = '0;
          if (tick) begin
            w_state_nxt = S_RISE1;
            w_beat_nxt  = 1'b1;
          end
        end
        S_RISE1: begin
          if (tick) begin
            w_level_nxt = w_up1;
            if (w_up1 == 8'hFF) w_state_nxt = S_FALL1;
          end
        end
        S_FALL1: begin
          if (tick) begin
            w_level_nxt = w_dn;
            if (w_dn == '0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = '0;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (r_gap_cnt == GAP4) begin
              w_state_nxt = S_RISE2;
              w_gap_nxt   = '0;
              w_beat_nxt  = 1'b1;
            end else begin
              w_gap_nxt = r_gap_cnt + 4'd1;
            end
          end
        end
        S_RISE2: begin
          if (tick) begin
            w_level_nxt = w_up2;
            if (w_up2 == PEAK8) w_state_nxt = S_FALL2;
          end
        end
        S_FALL2: begin
          if (tick) begin
            w_level_nxt = w_dn;
            if (w_dn == '0) begin
              w_state_nxt = S_REST;
              w_rest_nxt  = rest_len;
            end
          end
        end
        S_REST: begin
          if (tick) begin
            if (r_rest_cnt == '0) begin
              w_state_nxt = S_RISE1;
              w_beat_nxt  = 1'b1;
            end else begin
              w_rest_nxt = r_rest_cnt - 4'd1;
            end
          end
        end
        default: begin
          // Code 7 is unreachable in normal operation; return to IDLE if it ever appears.
          w_state_nxt = S_IDLE;
          w_level_nxt = '0;
          w_gap_nxt   = '0;
          w_rest_nxt  = '0;
        end
      endcase
    end
  end

  // PWM carrier. The duty latch updates on the same edge that pwm_cnt wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
      r_lvl_lat <= '0;
      r_pwm     <= 1'b0;
    end else begin
      if (r_pre == PRE_TC) begin
        r_pre     <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
        if (r_pwm_cnt == 8'hFF) r_lvl_lat <= r_level;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_pwm <= (r_pwm_cnt < r_lvl_lat);
    end
  end

  assign pwm_out = r_pwm;
  assign level   = r_level;
  assign phase   = r_state;
  assign beat    = r_beat;

endmodule

// File: tb/tb_heartbeat_pwm.sv
// tb_heartbeat_pwm
//   Directed, self-checking bench for heartbeat_pwm. Runs with PRESCALE=0 so
//   that one PWM period lasts 256 clocks.
module tb_heartbeat_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       tick;
  logic [3:0] rest_len;
  logic       pwm_out;
  logic [7:0] level;
  logic [2:0] phase;
  logic       beat;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected envelope for one full cycle, starting from the IDLE tick that enters RISE1.
  int unsigned ph_a [18] = '{1,1,1,1,2,2,2,2,3,3,3,4,4,4,5,5,5,6};
  int unsigned lv_a [18] = '{0,64,128,192,255,191,127,63,0,0,0,0,64,128,160,96,32,0};

  heartbeat_pwm #(
    .PRESCALE (0),
    .STEP     (64),
    .PEAK2    (160),
    .GAP_TICKS(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .tick    (tick),
    .rest_len(rest_len),
    .pwm_out (pwm_out),
    .level   (level),
    .phase   (phase),
    .beat    (beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A one-clock tick, then a check of the result, then a check that beat drops after one clock.
  task automatic do_tick(input int ph, input int lv, input bit b, input string tag);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk({tag, "_phase"}, phase, ph);
    chk({tag, "_level"}, level, lv);
    chk({tag, "_beat"}, beat, b);
    @(negedge clk);
    chk({tag, "_beat_drop"}, beat, 0);
    repeat (7) @(negedge clk);
  endtask

  // Stop at the negedge where pwm_out first shows a rising edge. The search is bounded.
  task automatic wait_rise(input string tag);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = pwm_out;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (!prev && pwm_out) found = 1'b1;
      prev = pwm_out;
    end
    chk({tag, "_rise_found"}, found, 1);
    chk({tag, "_rise_cnt"}, dut.r_pwm_cnt, 1);
  endtask

  // Count high samples over 256 clocks, starting with the current sample.
  // Optionally pulse tick at offset tick_at.
  task automatic measure(input int tick_at, output int ones);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (i == tick_at) tick = 1'b1;
      else tick = 1'b0;
      ones += int'(pwm_out);
    end
    tick = 1'b0;
  endtask

  initial begin
    int ones;
    rst_n    = 1'b0;
    enable   = 1'b0;
    tick     = 1'b0;
    rest_len = 4'd3;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_phase", phase, 0);
    chk("rst_beat", beat, 0);
    chk("rst_pwm", pwm_out, 0);

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hold_phase", phase, 0);

    // First cycle. rest_len=3 is latched on entry to REST.
    for (int i = 0; i < 18; i++)
      do_tick(ph_a[i], lv_a[i], (i == 0 || i == 11), $sformatf("c1_t%0d", i));
    // A change of rest_len during REST must be ignored: four REST ticks in total.
    rest_len = 4'd0;
    do_tick(6, 0, 0, "rest_a");
    do_tick(6, 0, 0, "rest_b");
    do_tick(6, 0, 0, "rest_c");
    do_tick(1, 0, 1, "rest_exit");

    // Second cycle. rest_len=0 gives an immediate restart.
    for (int i = 1; i < 18; i++)
      do_tick(ph_a[i], lv_a[i], (i == 11), $sformatf("c2_t%0d", i));
    do_tick(1, 0, 1, "rest0_exit");

    // Hold level at 128.
    do_tick(1, 64, 0, "hold_a");
    do_tick(1, 128, 0, "hold_b");
    repeat (520) @(negedge clk);
    wait_rise("duty128");
    measure(-1, ones);
    chk("duty128_ones", ones, 128);

    // Level changes partway through a period: that period keeps 128, and 192 applies from the next wrap.
    @(negedge clk);
    chk("mid_start_high", pwm_out, 1);
    measure(20, ones);
    chk("mid_level", level, 192);
    chk("mid_ones", ones, 128);
    @(negedge clk);
    measure(-1, ones);
    chk("next_ones", ones, 192);

    // Move forward into RISE2.
    do_tick(2, 255, 0, "f1_a");
    do_tick(2, 191, 0, "f1_b");
    do_tick(2, 127, 0, "f1_c");
    do_tick(2, 63, 0, "f1_d");
    do_tick(3, 0, 0, "gap_a");
    do_tick(3, 0, 0, "gap_b");
    do_tick(3, 0, 0, "gap_c");
    do_tick(4, 0, 1, "r2_entry");
    do_tick(4, 64, 0, "r2_a");

    // enable drops in the same cycle as a tick: enable wins.
    @(negedge clk);
    enable = 1'b0;
    tick   = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("dis_phase", phase, 0);
    chk("dis_level", level, 0);
    chk("dis_beat", beat, 0);
    @(negedge clk);
    chk("dis_beat2", beat, 0);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("dis_tick_phase", phase, 0);
    chk("dis_tick_beat", beat, 0);
    repeat (300) @(negedge clk);
    measure(-1, ones);
    chk("dis_ones", ones, 0);

    // Re-enable and run into FALL1, then reset asynchronously.
    enable = 1'b1;
    do_tick(1, 0, 1, "re_entry");
    do_tick(1, 64, 0, "re_a");
    do_tick(1, 128, 0, "re_b");
    do_tick(1, 192, 0, "re_c");
    do_tick(2, 255, 0, "re_d");
    do_tick(2, 191, 0, "re_e");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_phase", phase, 0);
    chk("arst_beat", beat, 0);
    chk("arst_pwm", pwm_out, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_phase", phase, 0);
    chk("post_rst_level", level, 0);
    chk("post_rst_beat", beat, 0);
    do_tick(1, 0, 1, "post_rst_entry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
